// File: rtl/safety_interlock_pkg.sv
// Shared constants for the laser safety interlock: FSM encodings, fault_code
// bit positions and default timing parameters.
package safety_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_FAULT    = 3'd2,
    ST_CLEARING = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_e;

  localparam int unsigned FC_LOWER = 0;
  localparam int unsigned FC_UPPER = 1;
  localparam int unsigned FC_RATE  = 2;

  localparam int unsigned DEF_CLEAR_HOLD    = 16;
  localparam int unsigned DEF_CLEAR_TIMEOUT = 1024;
  localparam int unsigned DEF_COOLDOWN      = 4096;
  localparam int unsigned DEF_CNT_W         = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser bringing a checker fail flag into clk.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/safety_interlock.sv
// Final laser-enable gate: latches the first checker fault, drives the clear
// handshake back to the checker and enforces a cooldown before re-arming.
module safety_interlock
  import safety_pkg::*;
#(
  parameter int unsigned CLEAR_HOLD    = DEF_CLEAR_HOLD,
  parameter int unsigned CLEAR_TIMEOUT = DEF_CLEAR_TIMEOUT,
  parameter int unsigned COOLDOWN      = DEF_COOLDOWN,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             arm_req,
  input  logic             clear_req,
  input  logic             laser_ready,
  input  logic             pulse_lower_fail,
  input  logic             pulse_upper_fail,
  input  logic             rate_fail,
  output logic             laser_enable,
  output logic             clear_fail,
  output logic             fault_latched,
  output logic [2:0]       fault_code,
  output logic             stuck_fault,
  output logic [CNT_W-1:0] fault_count,
  output logic [2:0]       state_out
);

  localparam int unsigned TW = $clog2(max_u(CLEAR_TIMEOUT, COOLDOWN));
  localparam logic [TW-1:0] HOLD_T = TW'(CLEAR_HOLD);
  localparam logic [TW-1:0] TOUT_T = TW'(CLEAR_TIMEOUT - 1);
  localparam logic [TW-1:0] CD_T   = TW'(COOLDOWN - 1);

  logic [2:0]    fail_sync;
  logic          fail_any;
  state_e        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic          fault_entry, stuck_set, clear_ok;
  logic          laser_enable_d, clear_fail_d;

  sync_2ff u_sync_lower (.clk(clk), .rstn(rstn), .d(pulse_lower_fail), .q(fail_sync[FC_LOWER]));
  sync_2ff u_sync_upper (.clk(clk), .rstn(rstn), .d(pulse_upper_fail), .q(fail_sync[FC_UPPER]));
  sync_2ff u_sync_rate  (.clk(clk), .rstn(rstn), .d(rate_fail),        .q(fail_sync[FC_RATE]));

  assign fail_any  = |fail_sync;
  assign state_out = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_DISARMED;
      timer <= '0;
    end else begin
      state <= state_d;
      timer <= timer_d;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    unique case (state)
      ST_DISARMED: begin
        if (fail_any)                    state_d = ST_FAULT;
        else if (arm_req && laser_ready) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (fail_any)      state_d = ST_FAULT;
        else if (!arm_req) state_d = ST_DISARMED;
      end
      ST_FAULT: begin
        if (clear_req) begin
          state_d = ST_CLEARING;
          timer_d = '0;
        end
      end
      ST_CLEARING: begin
        if ((timer >= HOLD_T) && !fail_any) begin
          state_d = ST_COOLDOWN;
          timer_d = '0;
        end else if (timer == TOUT_T) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      ST_COOLDOWN: begin
        if (fail_any)           state_d = ST_FAULT;
        else if (timer == CD_T) state_d = ST_DISARMED;
        else                    timer_d = timer + TW'(1);
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  // Outputs are registered from next-state values so enable drops on the same
  // edge the FSM enters FAULT, and clear_fail reaches the checker glitch-free.
  always_comb begin
    fault_entry    = (state_d == ST_FAULT) && (state != ST_FAULT) && (state != ST_CLEARING);
    stuck_set      = (state == ST_CLEARING) && (state_d == ST_FAULT);
    clear_ok       = (state == ST_CLEARING) && (state_d == ST_COOLDOWN);
    laser_enable_d = (state_d == ST_ARMED) && laser_ready;
    clear_fail_d   = (state_d == ST_CLEARING) && (timer_d < HOLD_T);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      laser_enable  <= 1'b0;
      clear_fail    <= 1'b0;
      fault_latched <= 1'b0;
      fault_code    <= '0;
      stuck_fault   <= 1'b0;
      fault_count   <= '0;
    end else begin
      laser_enable <= laser_enable_d;
      clear_fail   <= clear_fail_d;
      if (fault_entry) begin
        fault_latched <= 1'b1;
        fault_code    <= fail_sync;
        if (fault_count != '1) fault_count <= fault_count + CNT_W'(1);
      end else if (clear_ok) begin
        fault_latched <= 1'b0;
        fault_code    <= '0;
        stuck_fault   <= 1'b0;
      end else if (stuck_set) begin
        stuck_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_safety_interlock.sv
// Directed bench for safety_interlock: vector table for arm/fault entry, then
// hand sequences for clear timing, stuck flags, counter saturation and reset.
module tb_safety_interlock;

  localparam logic [2:0] S_DIS = 3'd0, S_ARM = 3'd1, S_FLT = 3'd2, S_CLR = 3'd3, S_CD = 3'd4;

  logic       clk = 1'b0, rstn = 1'b0;
  logic       arm_req = 1'b0, clear_req = 1'b0, laser_ready = 1'b0;
  logic       pulse_lower_fail = 1'b0, pulse_upper_fail = 1'b0, rate_fail = 1'b0;
  logic       laser_enable, clear_fail, fault_latched, stuck_fault;
  logic [2:0] fault_code, state_out;
  logic [7:0] fault_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  safety_interlock #(
    .CLEAR_HOLD(16), .CLEAR_TIMEOUT(1024), .COOLDOWN(4096), .CNT_W(8)
  ) dut (
    .clk(clk), .rstn(rstn), .arm_req(arm_req), .clear_req(clear_req),
    .laser_ready(laser_ready), .pulse_lower_fail(pulse_lower_fail),
    .pulse_upper_fail(pulse_upper_fail), .rate_fail(rate_fail),
    .laser_enable(laser_enable), .clear_fail(clear_fail),
    .fault_latched(fault_latched), .fault_code(fault_code),
    .stuck_fault(stuck_fault), .fault_count(fault_count), .state_out(state_out)
  );

  typedef struct {
    logic       arm, clr, rdy;
    logic [2:0] f;      // {rate, upper, lower}
    logic [2:0] st;
    logic       en, lat;
    logic [2:0] code;
    logic [7:0] cnt;
    logic       cf, stk;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string name);
    int cyc = 0;
    while (state_out !== s && cyc < bound) begin
      tick();
      cyc++;
    end
    chk(name, 32'(state_out), 32'(s));
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
  endtask

  function automatic vec_t mk(input logic a, c, r, input logic [2:0] f, input logic [2:0] st,
                              input logic en, lat, input logic [2:0] code, input logic [7:0] cnt);
    vec_t v;
    v = '{arm: a, clr: c, rdy: r, f: f, st: st, en: en, lat: lat, code: code, cnt: cnt,
          cf: 1'b0, stk: 1'b0};
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, cf_cnt, exp_cnt;
    logic en_seen;

    // Arm, laser_ready follow, ignored clear_req, arm drop, then an 8-clk upper fail.
    tbl[0]  = mk(1, 0, 1, 3'b000, S_ARM, 1, 0, 3'b000, 0);
    tbl[1]  = mk(1, 0, 0, 3'b000, S_ARM, 0, 0, 3'b000, 0);
    tbl[2]  = mk(1, 1, 1, 3'b000, S_ARM, 1, 0, 3'b000, 0);
    tbl[3]  = mk(0, 0, 1, 3'b000, S_DIS, 0, 0, 3'b000, 0);
    tbl[4]  = mk(1, 0, 0, 3'b000, S_DIS, 0, 0, 3'b000, 0);
    tbl[5]  = mk(1, 0, 1, 3'b000, S_ARM, 1, 0, 3'b000, 0);
    tbl[6]  = mk(1, 0, 1, 3'b010, S_ARM, 1, 0, 3'b000, 0);
    tbl[7]  = mk(1, 0, 1, 3'b010, S_ARM, 1, 0, 3'b000, 0);
    tbl[8]  = mk(1, 0, 1, 3'b010, S_FLT, 0, 1, 3'b010, 1);
    for (int i = 9; i < 14; i++) tbl[i] = mk(1, 0, 1, 3'b010, S_FLT, 0, 1, 3'b010, 1);
    for (int i = 14; i < 17; i++) tbl[i] = mk(0, 0, 1, 3'b000, S_FLT, 0, 1, 3'b010, 1);

    #12;
    chk("rst_state", 32'(state_out), 32'(S_DIS));
    chk("rst_en", 32'(laser_enable), 0);
    chk("rst_cf", 32'(clear_fail), 0);
    chk("rst_latched", 32'(fault_latched), 0);
    chk("rst_code", 32'(fault_code), 0);
    chk("rst_stuck", 32'(stuck_fault), 0);
    chk("rst_count", 32'(fault_count), 0);
    #11 rstn = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 17; i++) begin
      arm_req          = tbl[i].arm;
      clear_req        = tbl[i].clr;
      laser_ready      = tbl[i].rdy;
      rate_fail        = tbl[i].f[2];
      pulse_upper_fail = tbl[i].f[1];
      pulse_lower_fail = tbl[i].f[0];
      tick();
      chk($sformatf("v%0d_state", i), 32'(state_out), 32'(tbl[i].st));
      chk($sformatf("v%0d_en", i), 32'(laser_enable), 32'(tbl[i].en));
      chk($sformatf("v%0d_latched", i), 32'(fault_latched), 32'(tbl[i].lat));
      chk($sformatf("v%0d_code", i), 32'(fault_code), 32'(tbl[i].code));
      chk($sformatf("v%0d_count", i), 32'(fault_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_cf", i), 32'(clear_fail), 32'(tbl[i].cf));
      chk($sformatf("v%0d_stuck", i), 32'(stuck_fault), 32'(tbl[i].stk));
    end
    clear_req = 1'b0;

    // Clear with flags low, arm_req held through cooldown.
    arm_req = 1'b1;
    laser_ready = 1'b1;
    pulse_clear();
    chk("clr_enter", 32'(state_out), 32'(S_CLR));
    cf_cnt = 0;
    cyc = 0;
    while (state_out === S_CLR && cyc < 64) begin
      if (clear_fail) cf_cnt++;
      tick();
      cyc++;
    end
    chk("clear_hold_len", 32'(cf_cnt), 16);
    chk("cd_enter", 32'(state_out), 32'(S_CD));
    chk("cd_latched", 32'(fault_latched), 0);
    chk("cd_code", 32'(fault_code), 0);
    cyc = 0;
    en_seen = 1'b0;
    while (state_out === S_CD && cyc < 5000) begin
      if (laser_enable !== 1'b0) en_seen = 1'b1;
      tick();
      cyc++;
    end
    chk("cooldown_len", 32'(cyc), 4096);
    chk("cooldown_en_low", 32'(en_seen), 0);
    chk("cd_exit", 32'(state_out), 32'(S_DIS));
    tick();
    chk("rearm_state", 32'(state_out), 32'(S_ARM));
    chk("rearm_en", 32'(laser_enable), 1);

    // Simultaneous rate + lower, then a later upper fail must not alter the code.
    rate_fail = 1'b1;
    pulse_lower_fail = 1'b1;
    tick();
    pulse_lower_fail = 1'b0;
    tick();
    chk("sim_pre_state", 32'(state_out), 32'(S_ARM));
    tick();
    chk("sim_state", 32'(state_out), 32'(S_FLT));
    chk("sim_code", 32'(fault_code), 32'(3'b101));
    chk("sim_count", 32'(fault_count), 2);
    chk("sim_en", 32'(laser_enable), 0);
    rate_fail = 1'b0;
    pulse_upper_fail = 1'b1;
    repeat (4) tick();
    chk("late_upper_code", 32'(fault_code), 32'(3'b101));
    chk("late_upper_count", 32'(fault_count), 2);
    pulse_upper_fail = 1'b0;
    repeat (3) tick();

    // Stuck lower flag through a clear.
    pulse_lower_fail = 1'b1;
    repeat (3) tick();
    pulse_clear();
    cyc = 0;
    while (state_out === S_CLR && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("stuck_len", 32'(cyc), 1024);
    chk("stuck_state", 32'(state_out), 32'(S_FLT));
    chk("stuck_flag", 32'(stuck_fault), 1);
    chk("stuck_count", 32'(fault_count), 2);
    chk("stuck_code", 32'(fault_code), 32'(3'b101));
    chk("stuck_latched", 32'(fault_latched), 1);
    chk("stuck_cf", 32'(clear_fail), 0);
    pulse_lower_fail = 1'b0;
    repeat (3) tick();
    pulse_clear();
    wait_state(S_CD, 40, "unstuck_cd");
    chk("unstuck_flag", 32'(stuck_fault), 0);
    chk("unstuck_latched", 32'(fault_latched), 0);

    // Repeated faults from COOLDOWN drive the counter to saturation.
    exp_cnt = 2;
    for (int i = 0; i < 300; i++) begin
      rate_fail = 1'b1;
      wait_state(S_FLT, 10, "sat_fault");
      rate_fail = 1'b0;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk("sat_count", 32'(fault_count), 32'(exp_cnt));
      repeat (3) tick();
      pulse_clear();
      wait_state(S_CD, 40, "sat_cd");
    end
    chk("sat_final", 32'(fault_count), 255);

    // Asynchronous reset in the middle of CLEARING.
    rate_fail = 1'b1;
    wait_state(S_FLT, 10, "rst_fault");
    rate_fail = 1'b0;
    repeat (3) tick();
    pulse_clear();
    repeat (3) tick();
    chk("rstmid_pre_cf", 32'(clear_fail), 1);
    chk("rstmid_pre_state", 32'(state_out), 32'(S_CLR));
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_cf", 32'(clear_fail), 0);
    chk("rstmid_en", 32'(laser_enable), 0);
    chk("rstmid_latched", 32'(fault_latched), 0);
    chk("rstmid_state", 32'(state_out), 32'(S_DIS));
    chk("rstmid_count", 32'(fault_count), 0);
    #3 rstn = 1'b1;
    arm_req = 1'b0;
    tick();
    chk("post_rst_state", 32'(state_out), 32'(S_DIS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/safety_interlock.md
Name: safety_interlock

Overview:
- Downstream consumer of the pulse-width/rate checker's fail flags; final gate on laser enable.
- Synchronises the three fail flags and latches the first fault with its cause.
- Drops laser_enable on the cycle after a synchronised fail; runs the clear_fail handshake back to the checker and enforces a cooldown before re-arm.

Parameters:
- CLEAR_HOLD, 16: clk cycles clear_fail is held high; must be >= 16, so the /8 checker clock samples it at least twice.
- CLEAR_TIMEOUT, 1024: clk cycles to wait for all fail flags to drop after clear before declaring a stuck fault.
- COOLDOWN, 4096: clk cycles after a successful clear before arm_req is accepted.
- CNT_W, 8: width of the saturating fault counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- arm_req  in  1  host request to enable laser (level)
- clear_req  in  1  host request to clear a latched fault (single-cycle pulse)
- laser_ready  in  1  driver-ready status
- pulse_lower_fail  in  1  checker fail flag, width too short
- pulse_upper_fail  in  1  checker fail flag, width too long
- rate_fail  in  1  checker fail flag, period too short
- laser_enable  out  1  gate to laser driver
- clear_fail  out  1  clear strobe to checker
- fault_latched  out  1  a fault is held
- fault_code  out  3  first-fault cause: {rate, upper, lower}
- stuck_fault  out  1  clear attempted but flags persisted
- fault_count  out  CNT_W  number of faults latched, saturating
- state_out  out  3  current FSM state encoding

Behaviour:
- Reset values: all outputs 0; state DISARMED.
- Sync: each fail input passes through a 2-flop synchroniser (2 clk latency). fail_any is the OR of the synchronised flags.
- Encodings: DISARMED=0, ARMED=1, FAULT=2, CLEARING=3, COOLDOWN=4. These are shared constants.
- DISARMED:
  - laser_enable=0.
  - fail_any -> FAULT.
  - Otherwise, arm_req & laser_ready -> ARMED.
- ARMED:
  - laser_enable = laser_ready, registered.
  - fail_any -> FAULT. laser_enable is 0 in the first FAULT cycle: 3 clk worst case from raw fail to enable low.
  - Otherwise, !arm_req -> DISARMED.
- FAULT entry, same edge as the transition:
  - fault_latched=1.
  - fault_code = synchronised flags at that edge. Simultaneous flags are all captured.
  - fault_count increments and holds at all-ones.
- FAULT:
  - fault_code frozen; later flags are ignored.
  - clear_req -> CLEARING with timer=0.
  - clear_req arriving in any other state is ignored.
- CLEARING:
  - clear_fail=1 while timer < CLEAR_HOLD; timer increments each clk.
  - After the hold, once fail_any==0 -> COOLDOWN with timer=0; fault_latched, fault_code and stuck_fault clear.
  - If timer reaches CLEAR_TIMEOUT with fail_any still 1 -> stuck_fault=1 and back to FAULT. fault_code is kept and fault_count is not incremented.
- COOLDOWN:
  - laser_enable=0; timer increments.
  - fail_any -> FAULT, a new fault with normal entry actions.
  - timer == COOLDOWN-1 -> DISARMED. arm_req must then be presented, or still held, to re-arm.
- Timer: a single counter of clog2(max(CLEAR_TIMEOUT, COOLDOWN)) bits, shared by CLEARING and COOLDOWN; no wrap is possible.
- laser_ready low while ARMED: enable follows it low, state is unchanged, no fault.
- Reset mid-CLEARING: clear_fail drops asynchronously; all latches are lost (host rereads status).
- The synchroniser and FSM are purely clk-domain, with no dependence on the checker's divided clock.

Decomposition:
- Package safety_pkg holds:
  - state encodings;
  - fault_code bit indices (LOWER=0, UPPER=1, RATE=2);
  - default parameter constants.
- One sub-module, sync_2ff, a 1-bit synchroniser instantiated three times.

Test Plan:
- Arm with laser_ready=1, then pulse pulse_upper_fail for 8 clk -> laser_enable low 3 clk after rise; fault_code=3'b010; fault_count=1; state FAULT.
- From FAULT, pulse clear_req one clk with flags low -> clear_fail high exactly 16 clk; COOLDOWN 4096 clk; DISARMED; re-arm with arm_req held.
- Raise rate_fail and pulse_lower_fail on the same clk -> fault_code=3'b101; a later upper fail does not change fault_code.
- Hold pulse_lower_fail high through a clear -> stuck_fault=1 after 1024 clk; return to FAULT; fault_count unchanged.
- Inject 300 faults with clears between them -> fault_count saturates at 255.
- Assert rstn low during CLEARING -> clear_fail, laser_enable and fault_latched are 0 immediately; state DISARMED.
